// File: rtl/cdi_bus_pkg.sv
// Shared types and address map for the CD-i bus sequencer.
// Byte-address regions are checked in priority order by decode_region().
package cdi_bus_pkg;

  typedef enum logic [2:0] {
    REG_MCD212,
    REG_CDIC,
    REG_SLAVE,
    REG_NVRAM,
    REG_UNMAPPED,
    REG_ERR
  } region_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_FIX,
    ST_WAIT_ACK,
    ST_ACK,
    ST_BERR,
    ST_HOLD
  } bus_state_e;

  // Byte-address boundaries
  localparam logic [23:0] ERR_LO_BASE    = 24'h600000;
  localparam logic [23:0] ERR_LO_END     = 24'hCFFFFF;
  localparam logic [23:0] ERR_HI_BASE    = 24'hF00000;
  localparam logic [23:0] MCD212_LO_END  = 24'h27FFFF;
  localparam logic [23:0] MCD212_HI_BASE = 24'h400000;
  localparam logic [23:0] MCD212_HI_END  = 24'h5FFFFF;
  localparam logic [7:0]  CDIC_PAGE      = 8'h30;
  localparam logic [7:0]  SLAVE_PAGE     = 8'h31;
  localparam logic [7:0]  NVRAM_PAGE     = 8'h32;

  // Chip-select vector bit order: {mcd212, cdic, slave, nvram}
  function automatic region_e decode_region(input logic [23:1] addr);
    logic [23:0] a;
    region_e     r;
    a = {addr, 1'b0};
    if ((a >= ERR_LO_BASE && a <= ERR_LO_END) || a >= ERR_HI_BASE) r = REG_ERR;
    else if (a[23:16] == CDIC_PAGE)                                 r = REG_CDIC;
    else if (a[23:16] == SLAVE_PAGE)                                r = REG_SLAVE;
    else if (a[23:16] == NVRAM_PAGE)                                r = REG_NVRAM;
    else if (a <= MCD212_LO_END || (a >= MCD212_HI_BASE && a <= MCD212_HI_END))
                                                                    r = REG_MCD212;
    else                                                            r = REG_UNMAPPED;
    return r;
  endfunction

  function automatic logic [3:0] region_cs(input region_e r);
    logic [3:0] cs;
    case (r)
      REG_MCD212: cs = 4'b1000;
      REG_CDIC:   cs = 4'b0100;
      REG_SLAVE:  cs = 4'b0010;
      REG_NVRAM:  cs = 4'b0001;
      default:    cs = 4'b0000;
    endcase
    return cs;
  endfunction

endpackage

// File: rtl/cdi_edge_sync.sv
// One-flop rising-edge detector. History resets high so a pin that
// is already high at reset release does not look like an edge.
module cdi_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic hist;

  // Track the previous sample of din every cycle
  always_ff @(posedge clk) begin
    if (reset) hist <= 1'b1;
    else       hist <= din;
  end

  assign rise = din & ~hist;

endmodule

// File: rtl/cdi_bus_sequencer.sv
// SCC68070 bus sequencer: address decode, chip selects, wait states,
// target-ack handling, single-cycle ack/err and registered read data.
// Optional bus timeout in WAIT_ACK is enabled by defining BUS_TIMEOUT_EN.
module cdi_bus_sequencer
  import cdi_bus_pkg::*;
#(
  parameter int CDIC_WAIT       = 1,
  parameter int NVRAM_WAIT      = 2,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int SLAVE_IRQ_DELAY = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:1] cpu_addr,
  input  logic        cpu_as,
  input  logic        cpu_uds,
  input  logic        cpu_lds,
  input  logic        cpu_write,
  output logic        cpu_bus_ack,
  output logic        cpu_bus_err,
  output logic [15:0] cpu_data_in,
  output logic        cs_mcd212,
  output logic        cs_cdic,
  output logic        cs_slave,
  output logic        cs_nvram,
  input  logic        mcd212_ack,
  input  logic        slave_dtackn,
  input  logic [15:0] mcd212_dout,
  input  logic [15:0] cdic_dout,
  input  logic [15:0] slave_dout,
  input  logic [15:0] nvram_dout,
  output logic        slave_irq
);

  bus_state_e  state, next_state;
  region_e     region_q, dec_region;
  logic        write_q;
  logic [3:0]  wait_n, wcnt;
  logic [3:0]  cs_q;
  logic [15:0] irq_cnt;
  logic [15:0] rd_data;
  logic        start, dtack_rise, target_ack, fix_done, timeout_hit;

  assign start      = cpu_as && (cpu_uds || cpu_lds);
  assign dec_region = decode_region(cpu_addr);
  assign fix_done   = ({1'b0, wcnt} + 5'd1) >= {1'b0, wait_n};
  assign target_ack = (region_q == REG_MCD212) ? mcd212_ack :
                      (region_q == REG_SLAVE)  ? dtack_rise : 1'b0;

  cdi_edge_sync u_dtack_sync (
    .clk   (clk),
    .reset (reset),
    .din   (slave_dtackn),
    .rise  (dtack_rise)
  );

`ifdef BUS_TIMEOUT_EN
  logic [15:0] tcnt;
  assign timeout_hit = (tcnt == 16'(TIMEOUT_CYCLES - 1));

  // Count consecutive WAIT_ACK cycles; cleared whenever WAIT_ACK is left
  always_ff @(posedge clk) begin
    if (reset)                                                   tcnt <= '0;
    else if (state == ST_WAIT_ACK && next_state == ST_WAIT_ACK) tcnt <= tcnt + 16'd1;
    else                                                         tcnt <= '0;
  end
`else
  // No timeout hardware: WAIT_ACK waits for the target indefinitely
  assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  // Next-state decode
  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch is inferred.
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          case (dec_region)
            REG_ERR:               next_state = ST_BERR;
            REG_MCD212, REG_SLAVE: next_state = ST_WAIT_ACK;
            default:               next_state = ST_WAIT_FIX;
          endcase
        end
      end
      ST_WAIT_FIX: begin
        if (!cpu_as)       next_state = ST_IDLE;
        else if (fix_done) next_state = ST_ACK;
      end
      ST_WAIT_ACK: begin
        if (!cpu_as)          next_state = ST_IDLE;
        else if (target_ack)  next_state = ST_ACK;
        else if (timeout_hit) next_state = ST_BERR;
      end
      ST_ACK, ST_BERR: next_state = ST_HOLD;
      ST_HOLD:         if (!cpu_as) next_state = ST_IDLE;
      default:         next_state = ST_IDLE;
    endcase
  end

  // Read data mux; unmapped reads float high
  always_comb begin
    case (region_q)
      REG_MCD212: rd_data = mcd212_dout;
      REG_CDIC:   rd_data = cdic_dout;
      REG_SLAVE:  rd_data = slave_dout;
      REG_NVRAM:  rd_data = nvram_dout;
      default:    rd_data = 16'hFFFF;
    endcase
  end

  // State, cycle context, chip selects and the registered CPU responses
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      region_q    <= REG_UNMAPPED;
      write_q     <= 1'b0;
      wait_n      <= '0;
      wcnt        <= '0;
      cs_q        <= '0;
      cpu_bus_ack <= 1'b0;
      cpu_bus_err <= 1'b0;
      cpu_data_in <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state       <= next_state;
      cpu_bus_ack <= (state == ST_ACK);
      cpu_bus_err <= (state == ST_BERR);
      if (state == ST_ACK && !write_q) cpu_data_in <= rd_data;

      if (state == ST_IDLE && start) begin
        region_q <= dec_region;
        write_q  <= cpu_write;
        cs_q     <= region_cs(dec_region);
        case (dec_region)
          REG_CDIC:  wait_n <= 4'(CDIC_WAIT);
          REG_NVRAM: wait_n <= 4'(NVRAM_WAIT);
          default:   wait_n <= 4'd0;
        endcase
      end else if (next_state == ST_HOLD || next_state == ST_IDLE) begin
        cs_q <= '0;
      end

      if (state == ST_WAIT_FIX && next_state == ST_WAIT_FIX) wcnt <= wcnt + 4'd1;
      else                                                   wcnt <= '0;
    end
  end

  // Slave IRQ cooldown: reload on each slave cycle start, pulse when it reaches 1
  always_ff @(posedge clk) begin
    if (reset)                                                  irq_cnt <= '0;
    else if (state == ST_IDLE && start && dec_region == REG_SLAVE) irq_cnt <= 16'(SLAVE_IRQ_DELAY);
    else if (irq_cnt != 16'd0)                                  irq_cnt <= irq_cnt - 16'd1;
  end

  assign slave_irq = (irq_cnt == 16'd1);
  assign {cs_mcd212, cs_cdic, cs_slave, cs_nvram} = cs_q;

endmodule
